// File: rtl/para_result_collector.sv
// Round-robin collector for the BitNet lane result handshake.
// Captures one lane's 32-word vector and streams it out in beats.
module para_result_collector #(
    parameter int  PARA_WIDTH = 16,
    parameter int  OUT_WORDS  = 4,
    parameter int  LANE_W     = 4,
    localparam int NBEATS     = 32 / OUT_WORDS,
    localparam int BEAT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    localparam int BEAT_BITS  = OUT_WORDS * 32
) (
    input  logic                       clk,
    input  logic                       rst_n_i,
    input  logic [PARA_WIDTH-1:0]      lane_valid_i,
    output logic [PARA_WIDTH-1:0]      lane_ready_o,
    input  logic [PARA_WIDTH*1024-1:0] lane_result_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [BEAT_BITS-1:0]       out_data_o,
    output logic [LANE_W-1:0]          out_lane_o,
    output logic [BEAT_W-1:0]          out_beat_o,
    output logic                       out_last_o,
    output logic [31:0]                pkt_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_SEND
    } state_t;

    state_t state_q, state_d;

    logic [LANE_W-1:0]     grant_q, grant_d;
    logic [LANE_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [PARA_WIDTH-1:0] lane_ready_q, lane_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           pkt_cnt_q, pkt_cnt_d;
    logic                  capture_en;
    logic [BEAT_BITS-1:0]  buf_q [NBEATS];

    logic [2*PARA_WIDTH-1:0] rot_w;
    logic [PARA_WIDTH-1:0]   rot;
    logic [LANE_W:0]         sum;
    logic [LANE_W-1:0]       arb_idx;
    logic                    arb_any;
    logic                    capture_ok;
    logic                    accept;
    logic                    last_beat;
    logic [LANE_W-1:0]       grant_nxt;
    logic [1023:0]           lane_sel;

    assign arb_any    = |lane_valid_i;
    assign capture_ok = lane_valid_i[grant_q];
    assign accept     = out_valid_q & out_ready_i;
    assign last_beat  = (beat_q == BEAT_W'(NBEATS - 1));
    assign grant_nxt  = (grant_q == LANE_W'(PARA_WIDTH - 1)) ?
                        '0 : grant_q + LANE_W'(1);
    assign lane_sel   = 1024'(lane_result_i >> {grant_q, 10'b0});

    // Rotate so bit 0 is rr_ptr; the lowest set bit is the grant.
    assign rot_w = {lane_valid_i, lane_valid_i} >> rr_ptr_q;
    assign rot   = rot_w[PARA_WIDTH-1:0];

    always_comb begin
        arb_idx = '0;
        sum     = '0;
        for (int i = PARA_WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = (LANE_W + 1)'(rr_ptr_q) + (LANE_W + 1)'(i);
                if (sum >= (LANE_W + 1)'(PARA_WIDTH))
                    sum = sum - (LANE_W + 1)'(PARA_WIDTH);
                arb_idx = sum[LANE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (arb_any) state_d = S_CAPTURE;
            S_CAPTURE: state_d = capture_ok ? S_SEND : S_IDLE;
            S_SEND:    if (accept && last_beat) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        beat_d       = beat_q;
        lane_ready_d = '0;
        out_valid_d  = out_valid_q;
        pkt_cnt_d    = pkt_cnt_q;
        capture_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    grant_d      = arb_idx;
                    lane_ready_d = PARA_WIDTH'(1) << arb_idx;
                end
            end
            S_CAPTURE: begin
                if (capture_ok) begin
                    capture_en  = 1'b1;
                    beat_d      = '0;
                    out_valid_d = 1'b1;
                end
            end
            S_SEND: begin
                if (accept) begin
                    if (last_beat) begin
                        out_valid_d = 1'b0;
                        rr_ptr_d    = grant_nxt;
                        pkt_cnt_d   = pkt_cnt_q + 32'd1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: out_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            beat_q       <= '0;
            lane_ready_q <= '0;
            out_valid_q  <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_q       <= beat_d;
            lane_ready_q <= lane_ready_d;
            out_valid_q  <= out_valid_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NBEATS; k++)
                buf_q[k] <= '0;
        end else if (capture_en) begin
            for (int k = 0; k < NBEATS; k++)
                buf_q[k] <= lane_sel[k*BEAT_BITS +: BEAT_BITS];
        end
    end

    assign lane_ready_o = lane_ready_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = buf_q[beat_q];
    assign out_lane_o   = grant_q;
    assign out_beat_o   = beat_q;
    assign out_last_o   = out_valid_q & last_beat;
    assign pkt_count_o  = pkt_cnt_q;

endmodule
